// File: rtl/sha_1_pkg.sv
`default_nettype none
// =============================================================================
// sha_1_pkg : shared state encoding, constants and last-word padding helpers
// Rev 1.0
// =============================================================================
package sha_1_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_FILL      = 4'd1;
    localparam logic [3:0] ST_PAD80     = 4'd2;
    localparam logic [3:0] ST_ZERO      = 4'd3;
    localparam logic [3:0] ST_LEN_HI    = 4'd4;
    localparam logic [3:0] ST_LEN_LO    = 4'd5;
    localparam logic [3:0] ST_SEND_WAIT = 4'd6;
    localparam logic [3:0] ST_SEND      = 4'd7;
    localparam logic [3:0] ST_GAP       = 4'd8;

    // What the FSM resumes with once the buffered block has been streamed out
    localparam logic [1:0] NX_DONE  = 2'd0;
    localparam logic [1:0] NX_FILL  = 2'd1;
    localparam logic [1:0] NX_PAD80 = 2'd2;
    localparam logic [1:0] NX_ZERO  = 2'd3;

    localparam logic [31:0] PAD_WORD  = 32'h8000_0000;
    localparam int          BLK_WORDS = 16;

    function automatic logic [31:0] byte_mask(input logic [2:0] b);
        case (b)
            3'd0:    byte_mask = 32'h0000_0000;
            3'd1:    byte_mask = 32'hFF00_0000;
            3'd2:    byte_mask = 32'hFFFF_0000;
            3'd3:    byte_mask = 32'hFFFF_FF00;
            default: byte_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Keep the valid bytes and place the 0x80 marker right after them
    function automatic logic [31:0] last_word(input logic [31:0] d, input logic [2:0] b);
        if (b[2])
            last_word = d;
        else
            last_word = (d & byte_mask(b)) | (PAD_WORD >> {b[1:0], 3'b000});
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha_1_pad_buf.sv
`default_nettype none
// =============================================================================
// sha_1_pad_buf : 16x32 block buffer, one write port, one read port, sync clear
// Rev 1.0
// =============================================================================
module sha_1_pad_buf
    import sha_1_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_clr,
    input  logic        i_we,
    input  logic [3:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_raddr,
    output logic [31:0] o_rdata
);

    logic [31:0] r_mem [BLK_WORDS];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BLK_WORDS; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < BLK_WORDS; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sha_1_pad.sv
`default_nettype none
// =============================================================================
// sha_1_pad : SHA-1 message padder, buffers one 16-word block and streams it out
// Rev 1.0
// =============================================================================
module sha_1_pad
    import sha_1_pkg::*;
#(
    parameter int BLK_GAP = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] msg_data,
    input  logic        msg_vld,
    input  logic        msg_last,
    input  logic [2:0]  msg_bytes,
    output logic        msg_rdy,
    output logic [31:0] din,
    output logic        din_vld,
    output logic        use_pre_cv,
    output logic        sha_1_end,
    input  logic        busy,
    output logic        pad_idle
);

    localparam logic [3:0] GAP_LAST = (BLK_GAP > 1) ? 4'(BLK_GAP - 1) : 4'd0;

    logic [3:0]  r_state,   w_state_nx;
    logic [4:0]  r_idx,     w_idx_nx;
    logic [60:0] r_bytecnt, w_bytecnt_nx;
    logic [1:0]  r_next,    w_next_nx;
    logic        r_pre_cv,  w_pre_cv_nx;
    logic [3:0]  r_cnt,     w_cnt_nx;

    logic        w_clr, w_we, w_send;
    logic [31:0] w_wdata, w_rdata;
    logic [3:0]  w_mark_st;
    logic [63:0] w_bitlen;

    assign w_bitlen = {r_bytecnt, 3'b000};
    assign msg_rdy  = (r_state == ST_FILL) && !r_idx[4];

    // Where the marker lands decides whether the length still fits this block
    assign w_mark_st = (r_idx == 5'd13) ? ST_LEN_HI :
                       (r_idx == 5'd15) ? ST_SEND_WAIT : ST_ZERO;

    always_comb begin
        w_state_nx   = r_state;
        w_idx_nx     = r_idx;
        w_bytecnt_nx = r_bytecnt;
        w_next_nx    = r_next;
        w_pre_cv_nx  = r_pre_cv;
        w_cnt_nx     = r_cnt;
        w_clr        = 1'b0;
        w_we         = 1'b0;
        w_wdata      = '0;
        case (r_state)
            ST_IDLE: begin
                if (msg_vld) begin
                    w_state_nx = ST_FILL;
                    w_idx_nx   = '0;
                    w_clr      = 1'b1;
                end
            end
            ST_FILL: begin
                if (msg_vld && msg_rdy) begin
                    w_we     = 1'b1;
                    w_idx_nx = r_idx + 5'd1;
                    if (!msg_last) begin
                        w_wdata      = msg_data;
                        w_bytecnt_nx = r_bytecnt + 61'd4;
                        if (r_idx == 5'd15) begin
                            w_state_nx = ST_SEND_WAIT;
                            w_next_nx  = NX_FILL;
                        end
                    end else if (msg_bytes[2]) begin
                        w_wdata      = msg_data;
                        w_bytecnt_nx = r_bytecnt + 61'd4;
                        w_state_nx   = ST_PAD80;
                    end else begin
                        w_wdata      = last_word(msg_data, msg_bytes);
                        w_bytecnt_nx = r_bytecnt + 61'(msg_bytes);
                        w_state_nx   = w_mark_st;
                        w_next_nx    = NX_ZERO;
                    end
                end
            end
            ST_PAD80: begin
                if (r_idx[4]) begin
                    w_state_nx = ST_SEND_WAIT;
                    w_next_nx  = NX_PAD80;
                end else begin
                    w_we       = 1'b1;
                    w_wdata    = PAD_WORD;
                    w_idx_nx   = r_idx + 5'd1;
                    w_state_nx = w_mark_st;
                    w_next_nx  = NX_ZERO;
                end
            end
            ST_ZERO: begin
                w_we     = 1'b1;
                w_idx_nx = r_idx + 5'd1;
                if (r_idx == 5'd13) begin
                    w_state_nx = ST_LEN_HI;
                end else if (r_idx == 5'd15) begin
                    w_state_nx = ST_SEND_WAIT;
                    w_next_nx  = NX_ZERO;
                end
            end
            ST_LEN_HI: begin
                w_we       = 1'b1;
                w_wdata    = w_bitlen[63:32];
                w_idx_nx   = r_idx + 5'd1;
                w_state_nx = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                w_we       = 1'b1;
                w_wdata    = w_bitlen[31:0];
                w_idx_nx   = r_idx + 5'd1;
                w_state_nx = ST_SEND_WAIT;
                w_next_nx  = NX_DONE;
            end
            ST_SEND_WAIT: begin
                if (!busy) begin
                    w_state_nx = ST_SEND;
                    w_cnt_nx   = '0;
                end
            end
            ST_SEND: begin
                w_cnt_nx = r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    w_state_nx = ST_GAP;
                    w_cnt_nx   = '0;
                end
            end
            ST_GAP: begin
                w_cnt_nx = r_cnt + 4'd1;
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nx = '0;
                    w_idx_nx = '0;
                    if (r_next == NX_DONE) begin
                        w_state_nx   = ST_IDLE;
                        w_bytecnt_nx = '0;
                        w_pre_cv_nx  = 1'b0;
                    end else begin
                        w_pre_cv_nx = 1'b1;
                        w_clr       = 1'b1;
                        w_state_nx  = (r_next == NX_FILL)  ? ST_FILL  :
                                      (r_next == NX_PAD80) ? ST_PAD80 : ST_ZERO;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_bytecnt <= '0;
            r_next    <= NX_DONE;
            r_pre_cv  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_idx     <= w_idx_nx;
            r_bytecnt <= w_bytecnt_nx;
            r_next    <= w_next_nx;
            r_pre_cv  <= w_pre_cv_nx;
            r_cnt     <= w_cnt_nx;
        end
    end

    sha_1_pad_buf u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .i_clr   (w_clr),
        .i_we    (w_we),
        .i_waddr (r_idx[3:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_cnt),
        .o_rdata (w_rdata)
    );

    // Outputs are decoded from state so an async reset drops them at once
    assign w_send     = (r_state == ST_SEND);
    assign din_vld    = w_send;
    assign din        = w_send ? w_rdata : '0;
    assign use_pre_cv = w_send & r_pre_cv;
    assign sha_1_end  = w_send & (r_next == NX_DONE);
    assign pad_idle   = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sha_1_pad.sv
`default_nettype none
// =============================================================================
// tb_sha_1_pad : directed self-checking bench for the SHA-1 message padder
// Rev 1.0
// =============================================================================
module tb_sha_1_pad;

    localparam int LIM = 3000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] msg_data;
    logic        msg_vld;
    logic        msg_last;
    logic [2:0]  msg_bytes;
    logic        msg_rdy;
    logic [31:0] din;
    logic        din_vld;
    logic        use_pre_cv;
    logic        sha_1_end;
    logic        busy;
    logic        pad_idle;

    always #5 clk = ~clk;

    sha_1_pad #(.BLK_GAP(1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .msg_data   (msg_data),
        .msg_vld    (msg_vld),
        .msg_last   (msg_last),
        .msg_bytes  (msg_bytes),
        .msg_rdy    (msg_rdy),
        .din        (din),
        .din_vld    (din_vld),
        .use_pre_cv (use_pre_cv),
        .sha_1_end  (sha_1_end),
        .busy       (busy),
        .pad_idle   (pad_idle)
    );

    typedef struct packed {
        logic [15:0][31:0] w;
        logic              pre;
        logic              fin;
        logic              bad;
    } blk_t;

    blk_t        q[$];
    int          errors   = 0;
    int          checks   = 0;
    int          gap_errs = 0;
    logic [31:0] ew [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Collects streamed blocks; flags inconsistent side-band or holes mid-block
    initial begin : mon
        blk_t cur;
        int   cnt;
        cnt = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                cnt = 0;
            end else if (din_vld) begin
                if (cnt == 0) begin
                    cur.pre = use_pre_cv;
                    cur.fin = sha_1_end;
                    cur.bad = 1'b0;
                end else if (use_pre_cv !== cur.pre || sha_1_end !== cur.fin) begin
                    cur.bad = 1'b1;
                end
                cur.w[cnt] = din;
                cnt++;
                if (cnt == 16) begin
                    q.push_back(cur);
                    cnt = 0;
                end
            end else if (cnt != 0) begin
                gap_errs++;
                cnt = 0;
            end
        end
    end

    task automatic send_msg(input int n, input logic [31:0] w0, input logic [31:0] wr,
                            input logic [2:0] b);
        for (int i = 0; i < n; i++) begin
            int t;
            @(negedge clk);
            msg_data  = (i == 0) ? w0 : wr;
            msg_vld   = 1'b1;
            msg_last  = (i == n - 1);
            msg_bytes = (i == n - 1) ? b : 3'd0;
            t = 0;
            while (!msg_rdy && t < LIM) begin
                @(negedge clk);
                t++;
            end
            if (t >= LIM) check("msg_rdy_timeout", {63'd0, msg_rdy}, 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        msg_vld  = 1'b0;
        msg_last = 1'b0;
    endtask

    task automatic wait_blocks(input int n, input string tag);
        int t;
        t = 0;
        while (q.size() < n && t < LIM) begin
            @(negedge clk);
            t++;
        end
        if (q.size() < n) check({tag, "_timeout"}, 64'(q.size()), 64'(n));
    endtask

    task automatic expect_block(input string tag, input logic pre, input logic fin);
        blk_t b;
        wait_blocks(1, tag);
        if (q.size() > 0) begin
            b = q.pop_front();
            for (int i = 0; i < 16; i++)
                check($sformatf("%s_w%0d", tag, i), {32'd0, b.w[i]}, {32'd0, ew[i]});
            check({tag, "_use_pre_cv"}, {63'd0, b.pre}, {63'd0, pre});
            check({tag, "_sha_1_end"},  {63'd0, b.fin}, {63'd0, fin});
            check({tag, "_flags_const"}, {63'd0, b.bad}, 64'd0);
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (!pad_idle && t < LIM) begin
            @(negedge clk);
            t++;
        end
        if (!pad_idle) check({tag, "_idle_timeout"}, {63'd0, pad_idle}, 64'd1);
    endtask

    task automatic clr_ew();
        for (int i = 0; i < 16; i++) ew[i] = 32'h0;
    endtask

    task automatic set_ew_data(input int n);
        clr_ew();
        ew[0] = 32'hf1f1f1ce;
        for (int i = 1; i < n; i++) ew[i] = 32'hf1f1f1f2;
    endtask

    task automatic one_word(input string tag, input logic [31:0] d, input logic [2:0] b,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] len);
        send_msg(1, d, 32'h0, b);
        clr_ew();
        ew[0]  = w0;
        ew[1]  = w1;
        ew[15] = len;
        expect_block(tag, 1'b0, 1'b1);
        wait_idle(tag);
    endtask

    initial begin : stim
        int v;
        int t;
        rstn      = 1'b0;
        msg_data  = '0;
        msg_vld   = 1'b0;
        msg_last  = 1'b0;
        msg_bytes = '0;
        busy      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_din_vld",    {63'd0, din_vld},    64'd0);
        check("rst_msg_rdy",    {63'd0, msg_rdy},    64'd0);
        check("rst_pad_idle",   {63'd0, pad_idle},   64'd1);
        check("rst_din",        {32'd0, din},        64'd0);
        check("rst_use_pre_cv", {63'd0, use_pre_cv}, 64'd0);
        check("rst_sha_1_end",  {63'd0, sha_1_end},  64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // "abc"
        send_msg(1, 32'h61626300, 32'h0, 3'd3);
        check("abc_busy_not_idle", {63'd0, pad_idle}, 64'd0);
        clr_ew();
        ew[0]  = 32'h61626380;
        ew[15] = 32'h18;
        expect_block("abc", 1'b0, 1'b1);
        wait_idle("abc");

        one_word("b1",    32'h41FFFFFF, 3'd1, 32'h41800000, 32'h0,        32'h08);
        one_word("b2",    32'h6162FFFF, 3'd2, 32'h61628000, 32'h0,        32'h10);
        one_word("empty", 32'hDEADBEEF, 3'd0, 32'h80000000, 32'h0,        32'h00);
        one_word("b7",    32'h11223344, 3'd7, 32'h11223344, 32'h80000000, 32'h20);

        // 13 words: marker and length still fit
        send_msg(13, 32'hf1f1f1ce, 32'hf1f1f1f2, 3'd4);
        set_ew_data(13);
        ew[13] = 32'h80000000;
        ew[15] = 32'h1A0;
        expect_block("w13", 1'b0, 1'b1);
        wait_idle("w13");

        // 14 words: marker at 14, length spills to a second block
        send_msg(14, 32'hf1f1f1ce, 32'hf1f1f1f2, 3'd4);
        set_ew_data(14);
        ew[14] = 32'h80000000;
        expect_block("w14_b1", 1'b0, 1'b0);
        clr_ew();
        ew[15] = 32'h1C0;
        expect_block("w14_b2", 1'b1, 1'b1);
        wait_idle("w14");

        // 16 words with the core busy after block 1
        send_msg(16, 32'hf1f1f1ce, 32'hf1f1f1f2, 3'd4);
        wait_blocks(1, "w16_b1");
        busy = 1'b1;
        set_ew_data(16);
        expect_block("w16_b1", 1'b0, 1'b0);
        v = 0;
        repeat (40) begin
            @(negedge clk);
            if (din_vld) v++;
        end
        check("busy_hold_no_vld", 64'(v), 64'd0);
        busy = 1'b0;
        clr_ew();
        ew[0]  = 32'h80000000;
        ew[15] = 32'h200;
        expect_block("w16_b2", 1'b1, 1'b1);
        wait_idle("w16");

        // Reset in the middle of a chained block
        send_msg(14, 32'hf1f1f1ce, 32'hf1f1f1f2, 3'd4);
        set_ew_data(14);
        ew[14] = 32'h80000000;
        expect_block("rst_b1", 1'b0, 1'b0);
        t = 0;
        while (din_vld && t < LIM) begin
            @(negedge clk);
            t++;
        end
        while (!din_vld && t < LIM) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIM) check("rst_send_timeout", {63'd0, din_vld}, 64'd1);
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_mid_din_vld",  {63'd0, din_vld},  64'd0);
        check("rst_mid_pad_idle", {63'd0, pad_idle}, 64'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_discard", 64'(q.size()), 64'd0);
        send_msg(1, 32'h61626300, 32'h0, 3'd3);
        clr_ew();
        ew[0]  = 32'h61626380;
        ew[15] = 32'h18;
        expect_block("abc_after_rst", 1'b0, 1'b1);
        wait_idle("abc_after_rst");

        check("no_gaps", 64'(gap_errs), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
